if_fetch_stage: RTL and testbench

IF-stage fetch unit of the RV32 pipeline. Sits directly downstream of the next-PC generator: it registers the next PC as PCF and runs the instruction-memory request/ack handshake. It also owns the IF/ID pipeline register feeding decode. PCF is fed back to the next-PC generator, which returns PCF+4 or a branch/jal/jalr target on pc_in.

---
 rtl/rv_if_pkg.sv | 19 +
 rtl/if_id_reg.sv | 67 ++++++
 rtl/if_fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_if_pkg.sv
// Shared types and constants for the RV32 IF stage.
//   fetch_state_e : fetch FSM state encoding (2 bits)
//   RV_NOP_INSTR  : bubble instruction (addi x0,x0,0)
//   RV_RESET_PC   : default PC after reset
package rv_if_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_e;

  localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RV_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: reset > flush > stall (hold) > load > bubble.
//   clk, rst_n           : clock, synchronous active-low reset
//   load_i, pc_i, instr_i: load a real instruction
//   flush_i              : squash (valid=0, NOP, pc kept)
//   stall_i              : hold contents
//   bubble_i             : insert NOP, pc kept
//   pcd_o/instr_o/valid_o: register contents
module if_id_reg
  import rv_if_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            bubble_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pcd_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            valid_q, valid_d;

  // Next-value selection in priority order
  always_comb begin
    pcd_d   = pcd_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      pcd_d   = pcd_q;
    end else if (load_i) begin
      pcd_d   = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end else if (bubble_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcd_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pcd_q   <= pcd_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pcd_o   = pcd_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// RV32 IF stage: holds PCF, runs the imem request/ack handshake and owns
// the IF/ID register. pc_in (PCF+4 or a taken target) comes back from the
// next-PC generator; PCF only moves when a fetch completes or on redirect.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   pc_in, redirect            : next PC and taken-target flag
//   stall_f, flush_d           : hazard unit controls
//   pcf                        : current fetch PC
//   imem_req/addr/ack/rdata    : instruction memory handshake
//   pcd, instr_d, valid_d      : IF/ID register
// Optional (IF_PERF_CNT_EN): perf_fetch_cnt, perf_wait_cnt.
module if_fetch_stage
  import rv_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RV_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic            redirect,
  input  logic            stall_f,
  input  logic            flush_d,
  output logic [XLEN-1:0] pcf,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pcd,
  output logic [XLEN-1:0] instr_d,
  output logic            valid_d
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_wait_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;

  logic            ack_c;
  logic            load_c;
  logic [XLEN-1:0] load_pc_c;
  logic [XLEN-1:0] load_instr_c;

  // Acks arriving while no request is outstanding are stale
  assign ack_c = imem_ack & req_q;

  // Fetch FSM next state, PCF update and IF/ID load selection
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    load_c       = 1'b0;
    load_pc_c    = pcf_q;
    load_instr_c = imem_rdata;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          // Response (if any) belongs to the wrong path
          pcf_d   = pc_in;
          state_d = ack_c ? S_FETCH : S_DROP;
        end else if (ack_c && !stall_f) begin
          load_c = 1'b1;
          pcf_d  = pc_in;
        end else if (ack_c) begin
          hold_pc_d    = pcf_q;
          hold_instr_d = imem_rdata;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pcf_d   = pc_in;
          state_d = S_FETCH;
        end else if (!stall_f) begin
          load_c       = 1'b1;
          load_pc_c    = hold_pc_q;
          load_instr_c = hold_instr_q;
          pcf_d        = pc_in;
          state_d      = S_FETCH;
        end
      end
      S_DROP: begin
        // Wait out the stale request; later redirects still update PCF
        if (redirect) pcf_d = pc_in;
        if (ack_c) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Address is captured whenever the FSM is (re)entering or staying in FETCH
    addr_d = (state_d == S_FETCH) ? {pcf_d[XLEN-1:2], 2'b00} : addr_q;
    req_d  = (state_d == S_FETCH) || (state_d == S_DROP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pcf_q        <= RESET_PC;
      addr_q       <= '0;
      req_q        <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign pcf       = pcf_q;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_c),
    .flush_i (flush_d),
    .stall_i (stall_f),
    .bubble_i(!load_c),
    .pc_i    (load_pc_c),
    .instr_i (load_instr_c),
    .pcd_o   (pcd),
    .instr_o (instr_d),
    .valid_o (valid_d)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  // Count real IF/ID loads and request cycles without a response
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (load_c && !flush_d && !stall_f) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (req_q && !imem_ack)             wait_cnt_d  = wait_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: the bench acts as next-PC generator and
// instruction memory, keeps a reference model of the fetch stage, and a
// monitor compares the DUT against per-cycle and per-instruction queues.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        redirect, stall_f, flush_d;
  logic [31:0] pcf;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pcd, instr_d;
  logic        valid_d;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_wait_cnt;
`endif

  if_fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_in     (pc_in),
    .redirect  (redirect),
    .stall_f   (stall_f),
    .flush_d   (flush_d),
    .pcf       (pcf),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .pcd       (pcd),
    .instr_d   (instr_d),
    .valid_d   (valid_d)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_wait_cnt (perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] addr;
    logic        req;
    logic        valid;
    logic        fresh;   // a valid IF/ID after this edge must be a new load
    logic [31:0] fcnt;
    logic [31:0] wcnt;
  } cyc_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ins_t;

  cyc_t cyc_q[$];
  ins_t ins_q[$];

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_loads = 0;

  // Reference model: where the fetch unit is in its request lifecycle
  string       m_ph;     // "IDLE", "FETCH" (request live), "HOLD" (buffered), "DROP" (wrong path)
  logic [31:0] m_pcf, m_addr, m_buf_pc, m_buf_in, m_pcd, m_instr;
  logic        m_req, m_valid;
  logic [31:0] m_fc, m_wc;
  int          mem_cnt = -1;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge's worth of stimulus to the model
  task automatic model_edge(input logic rst, input logic redir, input logic [31:0] npc,
                            input logic stall, input logic flush, input logic ack,
                            input logic [31:0] rdata);
    logic        got;
    logic [31:0] gpc, gin;
    got = 1'b0; gpc = '0; gin = '0;
    if (!rst) begin
      m_ph = "IDLE"; m_pcf = RST_PC; m_req = 1'b0; m_addr = '0;
      m_pcd = '0; m_instr = NOP; m_valid = 1'b0; m_fc = '0; m_wc = '0;
    end else begin
      if (m_req && !ack) m_wc = m_wc + 1;
      if (m_ph == "IDLE") begin
        m_ph = "FETCH";
      end else if (m_ph == "FETCH") begin
        if (redir) begin
          m_pcf = npc;
          if (!ack) m_ph = "DROP";
        end else if (ack && !stall) begin
          got = 1'b1; gpc = m_pcf; gin = rdata; m_pcf = npc;
        end else if (ack) begin
          m_buf_pc = m_pcf; m_buf_in = rdata; m_ph = "HOLD";
        end
      end else if (m_ph == "HOLD") begin
        if (redir) begin
          m_pcf = npc; m_ph = "FETCH";
        end else if (!stall) begin
          got = 1'b1; gpc = m_buf_pc; gin = m_buf_in; m_pcf = npc; m_ph = "FETCH";
        end
      end else begin
        if (redir) m_pcf = npc;
        if (ack) m_ph = "FETCH";
      end
      m_req = (m_ph == "FETCH") || (m_ph == "DROP");
      if (m_ph == "FETCH") m_addr = m_pcf & ~32'h3;
      if (flush) begin
        m_valid = 1'b0; m_instr = NOP;
      end else if (!stall) begin
        if (got) begin
          m_valid = 1'b1; m_pcd = gpc; m_instr = gin;
          ins_q.push_back('{gpc, gin});
          m_fc = m_fc + 1;
          n_loads++;
        end else begin
          m_valid = 1'b0; m_instr = NOP;
        end
      end
    end
  endtask

  function automatic logic pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Drive one phase of random stimulus; memory latency is lat_lo..lat_hi extra cycles
  task automatic run_phase(input int cycles, input int lat_lo, input int lat_hi,
                           input int p_stall, input int p_flush, input int p_redir,
                           input int p_rst, input int p_spur);
    cyc_t e;
    repeat (cycles) begin
      @(negedge clk);
      rst_n    = !pct(p_rst);
      stall_f  = pct(p_stall);
      flush_d  = pct(p_flush);
      redirect = pct(p_redir);
      if (redirect)
        pc_in = pct(25) ? ($urandom & 32'h0000_03FF) : ($urandom & 32'h0000_03FC);
      else
        pc_in = m_pcf + 32'd4;
      if (m_req) begin
        if (mem_cnt < 0) mem_cnt = int'($urandom_range(lat_hi, lat_lo));
        if (mem_cnt == 0) begin
          imem_ack = 1'b1; imem_rdata = instr_at(m_addr); mem_cnt = -1;
        end else begin
          imem_ack = 1'b0; imem_rdata = $urandom; mem_cnt--;
        end
      end else begin
        mem_cnt    = -1;
        imem_ack   = pct(p_spur);
        imem_rdata = 32'hDEAD_BEEF;
      end
      model_edge(rst_n, redirect, pc_in, stall_f, flush_d, imem_ack & m_req, imem_rdata);
      e.pcf = m_pcf; e.addr = m_addr; e.req = m_req; e.valid = m_valid;
      e.fresh = rst_n && !stall_f && !flush_d;
      e.fcnt = m_fc; e.wcnt = m_wc;
      cyc_q.push_back(e);
    end
  endtask

  // Monitor: compare after every edge; a fresh valid IF/ID pops the instruction scoreboard
  initial begin
    cyc_t e;
    ins_t i;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("pcf", pcf, e.pcf);
        check("imem_req", 32'(imem_req), 32'(e.req));
        check("imem_addr", imem_addr, e.addr);
        check("valid_d", 32'(valid_d), 32'(e.valid));
        if (valid_d !== 1'b1) check("bubble_instr", instr_d, NOP);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, e.fcnt);
        check("perf_wait_cnt", perf_wait_cnt, e.wcnt);
`endif
        if (valid_d === 1'b1 && e.fresh) begin
          if (ins_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_load: got pc %h instr %h expected none", pcd, instr_d);
          end else begin
            i = ins_q.pop_front();
            check("pcd", pcd, i.pc);
            check("instr_d", instr_d, i.instr);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; pc_in = '0; redirect = 1'b0; stall_f = 1'b0; flush_d = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    model_edge(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);

    run_phase(2,    0, 0,  0,  0,  0, 100,  0);  // reset
    run_phase(12,   0, 0,  0,  0,  0,   0,  0);  // zero-wait streaming
    run_phase(16,   2, 2,  0,  0,  0,   0,  0);  // 3-cycle ack latency
    run_phase(40,   0, 2, 40,  0,  0,   0,  0);  // stalls / hold buffer
    run_phase(40,   1, 3,  0,  0, 30,   0,  0);  // redirects / drop
    run_phase(40,   0, 2,  0, 30,  0,   0,  0);  // flushes
    run_phase(30,   2, 3,  0,  0,  0,  10, 40);  // resets mid-wait, stale acks
    run_phase(3000, 0, 3, 20, 10, 10,   2, 20);  // everything mixed

    @(posedge clk);
    #2;
    check("ins_q_drained", 32'(ins_q.size()), 32'd0);
    check("enough_loads", 32'(n_loads > 200), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
